// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - exception/interrupt sequencer and CP0 write-port arbiter
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter logic [4:0]  REG_EPC      = 5'd14,
    parameter logic [4:0]  REG_CAUSE    = 5'd13,
    parameter logic [4:0]  REG_STATUS   = 5'd12,
    parameter logic [4:0]  REG_BADVADDR = 5'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_in_ds_i,
    input  logic [31:0] exc_fetch_addr_i,
    input  logic [31:0] exc_data_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        mtc0_we_i,
    input  logic [4:0]  mtc0_addr_i,
    input  logic [31:0] mtc0_data_i,
    output logic        mtc0_ready_o,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_wdata_o,
    output logic        cp0_hw_wr_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_W_EPC    = 3'd1;
    localparam logic [2:0] S_W_CAUSE  = 3'd2;
    localparam logic [2:0] S_W_STATUS = 3'd3;
    localparam logic [2:0] S_W_BADV   = 3'd4;
    localparam logic [2:0] S_REDIRECT = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d, status_q, status_d, cause_q, cause_d;
    logic [31:0] epc_q, epc_d, badv_q, badv_d;
    logic        in_ds_q, in_ds_d, eret_q, eret_d, badv_en_q, badv_en_d;

    logic        int_pend, event_w, sel_eret, sel_badv;
    logic [4:0]  sel_code;
    logic [31:0] sel_badv_addr, cause_wr;

    assign int_pend = (|(status_i[15:8] & cause_i[15:8])) & status_i[0] & ~status_i[1];
    assign event_w  = commit_valid_i & (int_pend | (|exc_flags_i));

    always_comb begin
        sel_code      = 5'd0;
        sel_badv      = 1'b0;
        sel_badv_addr = 32'd0;
        sel_eret      = 1'b0;
        if (int_pend) begin
            sel_code = 5'd0;
        end else if (exc_flags_i[0]) begin
            sel_code      = 5'd4;
            sel_badv      = 1'b1;
            sel_badv_addr = exc_fetch_addr_i;
        end else if (exc_flags_i[1]) begin
            sel_code = 5'd10;
        end else if (exc_flags_i[2]) begin
            sel_code = 5'd12;
        end else if (exc_flags_i[3]) begin
            sel_code = 5'd8;
        end else if (exc_flags_i[4]) begin
            sel_code = 5'd9;
        end else if (exc_flags_i[5] | exc_flags_i[6]) begin
            sel_code      = exc_flags_i[5] ? 5'd4 : 5'd5;
            sel_badv      = 1'b1;
            sel_badv_addr = exc_data_addr_i;
        end else begin
            sel_eret = exc_flags_i[7];
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pc_d      = pc_q;
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        badv_d    = badv_q;
        in_ds_d   = in_ds_q;
        eret_d    = eret_q;
        badv_en_d = badv_en_q;
        case (state_q)
            S_IDLE: begin
                if (event_w) begin
                    code_d    = sel_code;
                    pc_d      = exc_pc_i;
                    status_d  = status_i;
                    cause_d   = cause_i;
                    epc_d     = epc_i;
                    badv_d    = sel_badv_addr;
                    in_ds_d   = exc_in_ds_i;
                    eret_d    = sel_eret;
                    badv_en_d = sel_badv;
                    // EXL already set: the original EPC must survive a nested trap
                    if (sel_eret)          state_d = S_W_STATUS;
                    else if (status_i[1])  state_d = S_W_CAUSE;
                    else                   state_d = S_W_EPC;
                end
            end
            S_W_EPC:    state_d = S_W_CAUSE;
            S_W_CAUSE:  state_d = S_W_STATUS;
            S_W_STATUS: state_d = (!eret_q && badv_en_q) ? S_W_BADV : S_REDIRECT;
            S_W_BADV:   state_d = S_REDIRECT;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            code_q    <= 5'd0;
            pc_q      <= 32'd0;
            status_q  <= 32'd0;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            badv_q    <= 32'd0;
            in_ds_q   <= 1'b0;
            eret_q    <= 1'b0;
            badv_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pc_q      <= pc_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            badv_q    <= badv_d;
            in_ds_q   <= in_ds_d;
            eret_q    <= eret_d;
            badv_en_q <= badv_en_d;
        end
    end

    always_comb begin
        cause_wr      = cause_q;
        cause_wr[6:2] = code_q;
        if (!status_q[1]) cause_wr[31] = in_ds_q;
    end

    always_comb begin
        mtc0_ready_o     = 1'b0;
        cp0_we_o         = 1'b0;
        cp0_waddr_o      = 5'd0;
        cp0_wdata_o      = 32'd0;
        cp0_hw_wr_o      = 1'b0;
        stall_o          = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;
        // outputs are held quiet for the whole time reset is asserted
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (event_w) begin
                        stall_o = 1'b1;
                    end else begin
                        mtc0_ready_o = 1'b1;
                        cp0_we_o     = mtc0_we_i;
                        cp0_waddr_o  = mtc0_addr_i;
                        cp0_wdata_o  = mtc0_data_i;
                    end
                end
                S_W_EPC: begin
                    stall_o     = 1'b1;
                    cp0_we_o    = 1'b1;
                    cp0_hw_wr_o = 1'b1;
                    cp0_waddr_o = REG_EPC;
                    cp0_wdata_o = in_ds_q ? (pc_q - 32'd4) : pc_q;
                end
                S_W_CAUSE: begin
                    stall_o     = 1'b1;
                    cp0_we_o    = 1'b1;
                    cp0_hw_wr_o = 1'b1;
                    cp0_waddr_o = REG_CAUSE;
                    cp0_wdata_o = cause_wr;
                end
                S_W_STATUS: begin
                    stall_o     = 1'b1;
                    cp0_we_o    = 1'b1;
                    cp0_hw_wr_o = 1'b1;
                    cp0_waddr_o = REG_STATUS;
                    cp0_wdata_o = eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
                end
                S_W_BADV: begin
                    stall_o     = 1'b1;
                    cp0_we_o    = 1'b1;
                    cp0_hw_wr_o = 1'b1;
                    cp0_waddr_o = REG_BADVADDR;
                    cp0_wdata_o = badv_q;
                end
                S_REDIRECT: begin
                    flush_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = eret_q ? epc_q : EXC_VECTOR;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt sequencer in front of the CP0 register file.
- At the commit point (MEM stage) it detects interrupts and synchronous exceptions, picks one by priority, and stalls the pipeline.
- It drives CP0's single write port through a multi-cycle EPC/Cause/Status/BadVAddr update, then issues a flush and a PC redirect.
- It also arbitrates that write port between normal mtc0 writes and its own trap writes, and sequences ERET.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect target for all exceptions and interrupts
REG_EPC, 5'd14, CP0 address of EPC
REG_CAUSE, 5'd13, CP0 address of Cause
REG_STATUS, 5'd12, CP0 address of Status
REG_BADVADDR, 5'd8, CP0 address of BadVAddr

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
commit_valid_i  in  1  valid instruction at commit point; exceptions and interrupts are accepted only when high
exc_flags_i  in  8  [0]AdEL-fetch [1]RI [2]Ov [3]Sys [4]Bp [5]AdEL-data [6]AdES [7]ERET
exc_pc_i  in  32  PC of committing instruction
exc_in_ds_i  in  1  committing instruction is in a delay slot
exc_fetch_addr_i  in  32  faulting fetch address
exc_data_addr_i  in  32  faulting load/store address
status_i, cause_i, epc_i  in  32 each  current CP0 values
mtc0_we_i  in  1  pipeline CP0 write request
mtc0_addr_i  in  5  CP0 register address for the pipeline write
mtc0_data_i  in  32  write data for the pipeline write
mtc0_ready_o  out  1  pipeline write accepted this cycle
cp0_we_o  out  1  CP0 write enable
cp0_waddr_o  out  5  CP0 write address
cp0_wdata_o  out  32  CP0 write data
cp0_hw_wr_o  out  1  controller-originated write; CP0 writes all bits (Cause[31],[6:2], Status[1])
stall_o  out  1  freeze pipeline
flush_o  out  1  one-cycle flush pulse
redirect_valid_o  out  1  redirect strobe, coincident with flush_o
redirect_pc_o  out  32  redirect target

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all registered outputs and captured fields cleared to 0.
- Interrupt pending condition: int_pend = |(status_i[15:8] & cause_i[15:8]) & status_i[0] & ~status_i[1].
- Event in IDLE: event = commit_valid_i & (int_pend | |exc_flags_i).
- Priority and ExcCode:
  - Int(0) > AdEL-fetch(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdEL-data(4) > AdES(5).
  - ERET is taken only if no other source is set.
- Capture cycle (IDLE with event):
  - Latch code, pc, in_ds, status_i, cause_i, epc_i.
  - Latch badvaddr: fetch addr for AdEL-fetch, data addr for AdEL-data/AdES.
  - stall_o=1 combinationally.
  - mtc0_ready_o=0; the requester holds its write.
  - Next state per the rules below.
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, W_BADV, REDIRECT. stall_o=1 in every non-IDLE state.
- Exception path: W_EPC -> W_CAUSE -> W_STATUS -> (W_BADV if AdEL/AdES) -> REDIRECT.
  - If captured status EXL=1: skip W_EPC; W_CAUSE leaves BD unchanged; ExcCode is still written.
- W_EPC: write EPC = in_ds ? pc-4 : pc. Subtraction is mod 2^32, so 0 wraps to 32'hFFFFFFFC.
- W_CAUSE: write cause_cap with [31]=in_ds and [6:2]=code; all other bits unchanged.
- W_STATUS:
  - Exception: write status_cap | 32'h2.
  - ERET: write status_cap & ~32'h2.
- W_BADV: write the captured badvaddr.
- ERET path: IDLE -> W_STATUS -> REDIRECT; target = epc_i latched in the capture cycle.
- Trap writes: cp0_we_o=1 and cp0_hw_wr_o=1 for exactly one cycle per write state.
- REDIRECT:
  - flush_o=1, redirect_valid_o=1, redirect_pc_o = EXC_VECTOR (or the captured EPC for ERET), stall_o=0.
  - Next state IDLE; no new event is accepted in this cycle.
- Latency:
  - Exception without EXL and without BadVAddr: capture + 3 writes + redirect = flush 4 cycles after capture.
  - AdEL/AdES: 5 cycles.
  - With EXL=1: one cycle less.
  - ERET: 2 cycles.
- IDLE, no event: cp0_* = mtc0_* pass-through (combinational), cp0_hw_wr_o=0, mtc0_ready_o=1.
- Non-IDLE: mtc0_ready_o=0 and cp0_we_o is driven only by trap writes.
- Inputs other than rst are ignored outside IDLE. Flag changes mid-sequence have no effect.
- Reset asserted mid-sequence aborts immediately: no flush, no redirect.
- Outputs flush_o, redirect_*, cp0_* in trap states are registered/state-decoded and glitch-free.

Test Plan:
- Sys: commit_valid=1, flags=8'h08, pc=32'h80000100, in_ds=0, status=32'h10000001 -> writes, in order:
  - EPC=32'h80000100;
  - Cause[6:2]=8, [31]=0;
  - Status=32'h10000003;
  - then flush/redirect to 32'hBFC00380, 4 cycles after capture.
- AdES in delay slot, data_addr=32'h00001003, pc=32'h80000204 -> EPC=32'h80000200, Cause[31]=1, ExcCode=5, BadVAddr write of 32'h00001003, flush at cycle 5.
- Interrupt + RI + mtc0 in same cycle:
  - status=32'h0000FF01, cause[15:8]=8'h04, flags=8'h02, mtc0_we=1.
  - Required: ExcCode=0; mtc0_ready_o=0 until the cycle after REDIRECT; mtc0 then passes through unchanged.
- EXL already set (status=32'h10000003) with Bp -> no EPC write, Cause ExcCode=9 with BD unchanged, flush 3 cycles after capture.
- ERET, epc_i=32'h80000400, status=32'h10000003 -> Status write 32'h10000001, redirect_pc_o=32'h80000400 at cycle 2; int_pend ignored because EXL=1 at capture.
- rst deasserted-to-asserted during W_CAUSE -> all outputs 0 immediately, no flush; after release, an idle mtc0 write passes through the next cycle.
